// File: rtl/q_action_select_if.sv
// ---------------------------------------------------------------------------
// q_action_select_if
//   Bundle of the request/result signals around the epsilon-greedy action
//   selector. The producer side (forward-propagation stage plus the result
//   consumer) uses the master modport. The selector uses the slave modport.
//
//   Request : start, q_1..q_4 (signed Q6.10), epsilon, explore_en
//   Result  : busy, done, action, q_sel, q_max, explored
//   Accept  : ack (consumer takes the result while done=1)
// ---------------------------------------------------------------------------
interface q_action_select_if #(
  parameter int DW = 16
);
  logic          start;
  logic [DW-1:0] q_1;
  logic [DW-1:0] q_2;
  logic [DW-1:0] q_3;
  logic [DW-1:0] q_4;
  logic [15:0]   epsilon;
  logic          explore_en;
  logic          ack;

  logic          busy;
  logic          done;
  logic [1:0]    action;
  logic [DW-1:0] q_sel;
  logic [DW-1:0] q_max;
  logic          explored;

  modport master (
    output start, q_1, q_2, q_3, q_4, epsilon, explore_en, ack,
    input  busy, done, action, q_sel, q_max, explored
  );

  modport slave (
    input  start, q_1, q_2, q_3, q_4, epsilon, explore_en, ack,
    output busy, done, action, q_sel, q_max, explored
  );
endinterface

// File: rtl/q_action_select.sv
// ---------------------------------------------------------------------------
// q_action_select
//   Epsilon-greedy action selector. On start it snapshots four signed Q-values,
//   scans them one per cycle for the greedy argmax (ties keep the lower index),
//   then draws one LFSR sample to decide between exploring and exploiting.
//   The result is held under a done/ack handshake. q_max is always the greedy
//   maximum so the TD-target logic sees it even on exploratory steps.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - q_action_select_if.slave (request, result and ack signals)
//
//   Timing: start sampled at edge E0 -> done=1 after edge E4.
// ---------------------------------------------------------------------------
module q_action_select #(
  parameter int          DW        = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  q_action_select_if.slave bus
);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0][DW-1:0] snap_q, snap_d;
  logic [DW-1:0]      best_q, best_d;
  logic [1:0]         best_idx_q, best_idx_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        lfsr_step;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               explored_q, explored_d;
  logic [1:0]         action_q, action_d;
  logic [DW-1:0]      q_sel_q, q_sel_d;
  logic [DW-1:0]      q_max_q, q_max_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      best_q     <= '0;
      best_idx_q <= 2'd0;
      idx_q      <= 2'd0;
      lfsr_q     <= SEED;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      explored_q <= 1'b0;
      action_q   <= 2'd0;
      q_sel_q    <= '0;
      q_max_q    <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      explored_q <= explored_d;
      action_q   <= action_d;
      q_sel_q    <= q_sel_d;
      q_max_q    <= q_max_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    explored_d = explored_q;
    action_d   = action_q;
    q_sel_d    = q_sel_q;
    q_max_d    = q_max_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d     = {bus.q_4, bus.q_3, bus.q_2, bus.q_1};
          best_d     = bus.q_1;
          best_idx_d = 2'd0;
          idx_d      = 2'd1;
          busy_d     = 1'b1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strictly greater only, so equal values keep the earlier index.
        if ($signed(snap_q[idx_q]) > $signed(best_q)) begin
          best_d     = snap_q[idx_q];
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        lfsr_d = lfsr_step;
        if (bus.explore_en && (lfsr_step < bus.epsilon)) begin
          action_d   = lfsr_step[15:14];
          explored_d = 1'b1;
        end else begin
          action_d   = best_idx_q;
          explored_d = 1'b0;
        end
        q_sel_d = snap_q[action_d];
        q_max_d = best_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.ack) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.action   = action_q;
  assign bus.q_sel    = q_sel_q;
  assign bus.q_max    = q_max_q;
  assign bus.explored = explored_q;

endmodule

// File: tb/tb_q_action_select.sv
// ---------------------------------------------------------------------------
// tb_q_action_select
//   Bench for the epsilon-greedy selector. A transaction-level model (argmax
//   over an array, one LFSR step per decision, a cycle count for latency)
//   predicts every output on every cycle; hand-computed literal runs pin the
//   model to known answers. Randomised runs then exercise ties, extremes,
//   ignored start/ack noise and the exploration rate.
// ---------------------------------------------------------------------------
module tb_q_action_select;
  logic clk;
  logic rst;

  q_action_select_if #(.DW(16)) bus ();

  q_action_select #(.DW(16), .LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit rate_on = 1'b0;
  int txn = 0;

  logic [15:0] pool [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};

  // ------------------------------------------------------------------ model
  logic signed [15:0] m_snap [4];
  logic               m_busy, m_done, m_expl;
  logic [1:0]         m_action;
  logic signed [15:0] m_qsel, m_qmax;
  logic [15:0]        m_lfsr;
  int                 m_cnt;
  int                 m_xcnt;
  int                 m_runs;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge rst) begin : model_p
    int          bi;
    logic [15:0] nx;
    logic [1:0]  a;
    if (!rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_expl   <= 1'b0;
      m_action <= 2'd0;
      m_qsel   <= '0;
      m_qmax   <= '0;
      m_lfsr   <= 16'hACE1;
      m_cnt    <= 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_snap[0] <= bus.q_1;
        m_snap[1] <= bus.q_2;
        m_snap[2] <= bus.q_3;
        m_snap[3] <= bus.q_4;
        m_busy    <= 1'b1;
        m_cnt     <= 0;
      end
    end else if (!m_done) begin
      if (m_cnt == 3) begin
        bi = 0;
        for (int i = 1; i < 4; i++) begin
          if (m_snap[i] > m_snap[bi]) bi = i;
        end
        nx = lfsr_adv(m_lfsr);
        if (bus.explore_en && (nx < bus.epsilon)) a = nx[15:14];
        else a = 2'(bi);
        m_expl   <= (a != 2'(bi)) || (bus.explore_en && (nx < bus.epsilon));
        m_action <= a;
        m_qsel   <= m_snap[a];
        m_qmax   <= m_snap[bi];
        m_lfsr   <= nx;
        m_done   <= 1'b1;
        if (rate_on) begin
          m_runs <= m_runs + 1;
          m_xcnt <= m_xcnt + ((bus.explore_en && (nx < bus.epsilon)) ? 1 : 0);
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (bus.ack) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  // ------------------------------------------------------- compare process
  logic prev_done = 1'b0;
  int   dut_x = 0;
  int   dut_runs = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp++;
      if ({bus.busy, bus.done, bus.action, bus.q_sel, bus.q_max, bus.explored} !==
          {m_busy, m_done, m_action, m_qsel, m_qmax, m_expl}) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t busy/done/act/qsel/qmax/expl got %b/%b/%0d/%0d/%0d/%b want %b/%b/%0d/%0d/%0d/%b",
                 $time, bus.busy, bus.done, bus.action, $signed(bus.q_sel), $signed(bus.q_max), bus.explored,
                 m_busy, m_done, m_action, m_qsel, m_qmax, m_expl);
      end
      if (rate_on && bus.done && !prev_done) begin
        dut_runs++;
        if (bus.explored) dut_x++;
      end
      prev_done <= bus.done;
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic run_lit(input string tag,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic en, input logic [15:0] eps,
                         input logic [1:0] x_act, input logic [15:0] x_qsel,
                         input logic [15:0] x_qmax, input logic x_expl, input int hold);
    @(negedge clk);
    bus.q_1 = a; bus.q_2 = b; bus.q_3 = c; bus.q_4 = d;
    bus.explore_en = en; bus.epsilon = eps;
    bus.start = 1'b1; bus.ack = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " busy_after_capture"}, 32'(bus.busy), 32'd1);
    chk({tag, " done_early"}, 32'(bus.done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, " done_early"}, 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk({tag, " done_at_latency"}, 32'(bus.done), 32'd1);
    chk({tag, " action"}, 32'(bus.action), 32'(x_act));
    chk({tag, " q_sel"}, 32'(bus.q_sel), 32'(x_qsel));
    chk({tag, " q_max"}, 32'(bus.q_max), 32'(x_qmax));
    chk({tag, " explored"}, 32'(bus.explored), 32'(x_expl));
    // Hold without ack while pulsing start with different data: nothing may move.
    for (int k = 0; k < hold; k++) begin
      bus.start = k[0];
      bus.q_1 = 16'h7FFF;
      @(negedge clk);
      chk({tag, " held_done"}, 32'(bus.done), 32'd1);
      chk({tag, " held_action"}, 32'(bus.action), 32'(x_act));
      chk({tag, " held_q_sel"}, 32'(bus.q_sel), 32'(x_qsel));
    end
    // start in the ack cycle must be ignored.
    bus.start = (hold > 0);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    bus.start = 1'b0;
    chk({tag, " released_done"}, 32'(bus.done), 32'd0);
    chk({tag, " released_busy"}, 32'(bus.busy), 32'd0);
    $display("txn %s: action=%0d q_sel=%0d q_max=%0d explored=%0b",
             tag, x_act, $signed(x_qsel), $signed(x_qmax), x_expl);
  endtask

  task automatic rand_run(input bit rate);
    int guard;
    bit logged;
    @(negedge clk);
    bus.q_1 = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
    bus.q_2 = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
    bus.q_3 = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
    bus.q_4 = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
    if (rate) begin
      bus.explore_en = 1'b1;
      bus.epsilon = 16'h4000;
    end else begin
      bus.explore_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: bus.epsilon = 16'h0000;
        1: bus.epsilon = 16'hFFFF;
        default: bus.epsilon = 16'($urandom);
      endcase
    end
    bus.start = 1'b1;
    bus.ack = 1'b0;
    @(negedge clk);
    guard = 0;
    logged = 1'b0;
    while (m_busy && guard < 40) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.ack = ($urandom_range(0, 2) == 0);
      if (m_done && !logged) begin
        logged = 1'b1;
        txn++;
        $display("txn %0d: action=%0d q_sel=%0d q_max=%0d explored=%0b",
                 txn, m_action, m_qsel, m_qmax, m_expl);
      end
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    bus.ack = 1'b0;
    chk("run_completes_in_budget", 32'(guard < 40), 32'd1);
  endtask

  // ---------------------------------------------------------- watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    m_xcnt = 0;
    m_runs = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.ack = 1'b0;
    bus.q_1 = '0; bus.q_2 = '0; bus.q_3 = '0; bus.q_4 = '0;
    bus.epsilon = '0; bus.explore_en = 1'b0;
    #1 chk_on = 1'b1;
    #22 rst = 1'b1;

    @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset action", 32'(bus.action), 32'd0);
    chk("reset q_sel", 32'(bus.q_sel), 32'd0);
    chk("reset q_max", 32'(bus.q_max), 32'd0);
    chk("reset explored", 32'(bus.explored), 32'd0);

    // Greedy: (100,-5,300,200) -> action 2, 300/300.
    run_lit("greedy", 16'd100, 16'hFFFB, 16'd300, 16'd200, 1'b0, 16'h0000,
            2'd2, 16'd300, 16'd300, 1'b0, 0);
    // Ties among negatives keep the lower index; all-equal picks action 0.
    run_lit("tie_neg", 16'hFFF6, 16'hFFFD, 16'hFFF9, 16'hFFFD, 1'b0, 16'h0000,
            2'd1, 16'hFFFD, 16'hFFFD, 1'b0, 0);
    run_lit("tie_all", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0, 16'hFFFF,
            2'd0, 16'h0400, 16'h0400, 1'b0, 0);

    // Fresh LFSR: ACE1 steps to 59C3, top bits 01 -> explore picks action 1.
    do_reset();
    run_lit("explore", 16'd100, 16'hFFFB, 16'd300, 16'd200, 1'b1, 16'hFFFF,
            2'd1, 16'hFFFB, 16'd300, 1'b1, 0);
    // epsilon=0 never explores; also hold done for 10 cycles with start noise.
    run_lit("eps0_hold", 16'd100, 16'hFFFB, 16'd300, 16'd200, 1'b1, 16'h0000,
            2'd2, 16'd300, 16'd300, 1'b0, 10);

    // Reset in the middle of SCAN clears outputs at once and reseeds the LFSR.
    @(negedge clk);
    bus.q_1 = 16'd7; bus.q_2 = 16'd9; bus.q_3 = 16'd1; bus.q_4 = 16'd2;
    bus.explore_en = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    chk("midreset action", 32'(bus.action), 32'd0);
    chk("midreset q_sel", 32'(bus.q_sel), 32'd0);
    chk("midreset q_max", 32'(bus.q_max), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    run_lit("after_reset", 16'd100, 16'hFFFB, 16'd300, 16'd200, 1'b1, 16'hFFFF,
            2'd1, 16'hFFFB, 16'd300, 1'b1, 0);

    // Randomised runs with noise on start/ack, checked every cycle by the model.
    for (int r = 0; r < 1000; r++) rand_run(1'b0);

    // Exploration rate at epsilon = 0x4000 (25%).
    @(negedge clk);
    rate_on = 1'b1;
    for (int r = 0; r < 2000; r++) rand_run(1'b1);
    @(negedge clk);
    rate_on = 1'b0;
    chk("rate runs counted", 32'(dut_runs), 32'd2000);
    chk("explore count vs model", 32'(dut_x), 32'(m_xcnt));
    chk("explore rate within 25%+-3%",
        32'((dut_x * 100 >= dut_runs * 22) && (dut_x * 100 <= dut_runs * 28)), 32'd1);
    $display("explore rate: %0d of %0d runs", dut_x, dut_runs);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
